inv_mix_round_unit: RTL and testbench

Iterative AddRoundKey + InvMixColumns stage for the AES decryption datapath. It is the inverse-direction counterpart of the encryption MixColumns/AddRoundKey network. It sits after InvShiftRows/InvSubBytes in the decrypt round loop. Each 128-bit block is processed one column per cycle, with valid/ready handshakes on both sides, so one GF(2^8) column multiplier is shared across the four columns. A `skip_mix` flag supports the final decryption round, which is AddRoundKey only.

---
 rtl/inv_mix_round_unit.sv | 169 ++++++++++++++++
 tb/tb_inv_mix_round_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_round_unit.sv
// AES decrypt round stage: AddRoundKey followed by InvMixColumns, one column per cycle
// through a single shared GF(2^8) column multiplier, with valid/ready on both sides.
module inv_mix_round_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [1:0]     col_r;
    logic [127:0]   acc_r;
    logic           skip_r;
    logic           accept_s;
    logic           mix_en_s;
    logic [31:0]    col_in_s;
    logic [31:0]    col_mixed_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x8;
        x8    = xtime(xtime(xtime(b)));
        mul09 = x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2    = xtime(b);
        x8    = xtime(xtime(x2));
        mul0b = x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4    = xtime(xtime(b));
        x8    = xtime(x4);
        mul0d = x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2    = xtime(b);
        x4    = xtime(x2);
        x8    = xtime(x4);
        mul0e = x8 ^ x4 ^ x2;
    endfunction

    // Row r0 is the most significant byte of the column word.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        inv_mix_col = {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                       mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                       mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                       mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

    assign accept_s = in_valid && (state_r == ST_IDLE);
    assign mix_en_s = (state_r == ST_BUSY) && !skip_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a skip round still spends one cycle in BUSY without touching acc.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (skip_r || (col_r == 2'd3)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Select the column currently being transformed.
    always_comb begin
        col_in_s = 32'h0000_0000;
        case (col_r)
            2'd0:    col_in_s = acc_r[127:96];
            2'd1:    col_in_s = acc_r[95:64];
            2'd2:    col_in_s = acc_r[63:32];
            2'd3:    col_in_s = acc_r[31:0];
            default: col_in_s = 32'h0000_0000;
        endcase
    end

    assign col_mixed_s = inv_mix_col(col_in_s);

    // Accumulator, skip flag and column counter; col wraps to 0 exactly as BUSY exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= 128'h0;
            skip_r <= 1'b0;
            col_r  <= 2'd0;
        end else if (accept_s) begin
            acc_r  <= state_in ^ round_key;
            skip_r <= skip_mix;
            col_r  <= 2'd0;
        end else if (mix_en_s) begin
            case (col_r)
                2'd0:    acc_r[127:96] <= col_mixed_s;
                2'd1:    acc_r[95:64]  <= col_mixed_s;
                2'd2:    acc_r[63:32]  <= col_mixed_s;
                2'd3:    acc_r[31:0]   <= col_mixed_s;
                default: acc_r         <= acc_r;
            endcase
            col_r <= col_r + 2'd1;
        end else begin
            acc_r  <= acc_r;
            skip_r <= skip_r;
            col_r  <= col_r;
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign data_out  = acc_r;

endmodule

// File: tb/tb_inv_mix_round_unit.sv
// Self-checking bench for inv_mix_round_unit: directed vectors, backpressure, reset abort
// and a randomized stream checked against a generic GF(2^8) matrix model.
module tb_inv_mix_round_unit;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KEY_K    = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    inv_mix_round_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .skip_mix  (skip_mix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full polynomial product then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                           input logic sk);
        logic [127:0] x;
        logic [127:0] y;
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        x = st ^ key;
        if (sk) return x;
        y = x;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = x[127 - 8 * (4 * c + j) -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i + 4) % 4], a[j]);
                y[127 - 8 * (4 * c + i) -: 8] = r;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input logic [127:0] st, input logic [127:0] key, input logic sk,
                             input logic [127:0] exp, input int lat, input string tag);
        int n;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        state_in = st; round_key = key; skip_mix = sk; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; state_in = rand128(); round_key = rand128(); skip_mix = ~sk;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 128'(n), 128'(lat));
        check_eq({tag, "_data"}, data_out, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_after"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] exp_q [$];
        logic [127:0] a_st, a_key, b_st, b_key, exp_a, hold;
        logic         b_sk;
        int           n, sent, recv, cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        state_in = 128'h0; round_key = 128'h0; skip_mix = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready_during", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_data_out", data_out, 128'h0);

        // Directed vectors
        run_block(FIPS_IN, 128'h0, 1'b0, FIPS_OUT, 4, "fips");
        run_block(FIPS_IN ^ KEY_K, KEY_K, 1'b0, FIPS_OUT, 4, "keyxor");
        run_block(128'h00112233_44556677_8899aabb_ccddeeff, {4{32'hffffffff}}, 1'b1,
                  128'hffeeddcc_bbaa9988_77665544_33221100, 1, "final");

        // Backpressure with a second block waiting
        a_st = rand128(); a_key = rand128();
        b_st = rand128(); b_key = rand128(); b_sk = 1'($urandom_range(0, 1));
        exp_a = model(a_st, a_key, 1'b0);
        @(negedge clk);
        state_in = a_st; round_key = a_key; skip_mix = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        state_in = b_st; round_key = b_key; skip_mix = b_sk;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_reach_done", 128'(out_valid), 128'(1));
        hold = data_out;
        check_eq("bp_first_data", hold, exp_a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_data_stable", data_out, exp_a);
            check_eq("bp_in_ready_low", 128'(in_ready), 128'(0));
            check_eq("bp_out_valid_held", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_idle_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_b_accepted", 128'(in_ready), 128'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_b_data", data_out, model(b_st, b_key, b_sk));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during BUSY aborts the block
        @(negedge clk);
        state_in = rand128(); round_key = rand128(); skip_mix = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 128'(out_valid), 128'(0));
        check_eq("abort_in_ready", 128'(in_ready), 128'(1));
        check_eq("abort_data_out", data_out, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_output", 128'(out_valid), 128'(0));
            check_eq("abort_in_ready_after", 128'(in_ready), 128'(1));
        end

        // Randomized stream
        sent = 0; recv = 0; cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                state_in  = rand128();
                round_key = rand128();
                skip_mix  = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                exp_q.push_back(model(state_in, round_key, skip_mix));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand_extra_output", data_out, ~data_out);
                end else begin
                    check_eq("rand_data", data_out, exp_q.pop_front());
                end
                recv++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("rand_recv_count", 128'(recv), 128'(1000));
        check_eq("rand_sent_count", 128'(sent), 128'(1000));
        check_eq("rand_queue_empty", 128'(exp_q.size()), 128'(0));
        repeat (3) @(negedge clk);
        check_eq("rand_end_out_valid", 128'(out_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
